code_unpacker: RTL and testbench

Receive-path stage that sits directly upstream of the text expander. It accepts a byte stream from the channel receiver, in which 7-bit compressed text codes are bit-packed MSB-first with no padding (8 codes per 7 bytes). It re-slices that stream into one 7-bit code per handshake for the expander. A sync input realigns the bit buffer at frame starts. The block also flags codes outside the expander's defined range and counts the codes it emits.

---
 rtl/code_unpacker.sv | 91 +++++++++
 tb/tb_code_unpacker.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/code_unpacker.sv
// code_unpacker
// Re-slices a byte stream carrying MSB-first bit-packed 7-bit codes into one
// code per handshake. A sync pulse discards every buffered bit so the next
// byte starts a fresh code boundary.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   sync                  frame realign, clears buffer and code counter
//   in_byte/in_valid      packed input byte (bit 7 oldest) and its valid
//   in_ready              a byte can be accepted this cycle
//   code_out/code_valid   oldest 7 buffered bits (bit 6 oldest) and its valid
//   code_ready            downstream consumes code_out this cycle
//   code_err              emitted code is above MAX_CODE (informational)
//   code_cnt              codes emitted since reset or the last sync
module code_unpacker #(
  parameter int unsigned MAX_CODE = 94
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sync,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [6:0]  code_out,
  output logic        code_valid,
  input  logic        code_ready,
  output logic        code_err,
  output logic [15:0] code_cnt
);

  // Oldest bit sits at bits_q[13]; bits below the fill count are kept zero.
  logic [13:0] bits_q, bits_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] code_cnt_q, code_cnt_d;

  logic        accept, pop, has_code;
  logic [13:0] base_bits;
  logic [3:0]  base_cnt;

  always_comb begin
    has_code   = (cnt_q >= 4'd7);
    in_ready   = (cnt_q <= 4'd6) && !sync;
    code_valid = has_code && !sync;
    code_out   = has_code ? bits_q[13:7] : 7'd0;
    code_err   = code_valid && (32'(code_out) > MAX_CODE);
    code_cnt   = code_cnt_q;
  end

  always_comb begin
    accept     = in_valid && in_ready;
    pop        = code_valid && code_ready;
    base_bits  = bits_q;
    base_cnt   = cnt_q;
    bits_d     = bits_q;
    cnt_d      = cnt_q;
    code_cnt_d = code_cnt_q;

    if (sync) begin
      bits_d     = 14'd0;
      cnt_d      = 4'd0;
      code_cnt_d = 16'd0;
    end else begin
      // Pop first so the popped code always comes from the pre-append buffer.
      if (pop) begin
        base_bits  = bits_q << 7;
        base_cnt   = cnt_q - 4'd7;
        code_cnt_d = code_cnt_q + 16'd1;
      end
      bits_d = base_bits;
      cnt_d  = base_cnt;
      if (accept) begin
        // Place the byte directly behind the remaining bits.
        bits_d = base_bits | ({in_byte, 6'd0} >> base_cnt);
        cnt_d  = base_cnt + 4'd8;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits_q     <= 14'd0;
      cnt_q      <= 4'd0;
      code_cnt_q <= 16'd0;
    end else begin
      bits_q     <= bits_d;
      cnt_q      <= cnt_d;
      code_cnt_q <= code_cnt_d;
    end
  end

endmodule

// File: tb/tb_code_unpacker.sv
// Testbench for code_unpacker: directed scenarios plus random traffic, all
// checked cycle by cycle against a bit-queue reference model.
module tb_code_unpacker;

  localparam int unsigned MAX_CODE = 94;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sync;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  code_out;
  logic        code_valid;
  logic        code_ready;
  logic        code_err;
  logic [15:0] code_cnt;

  code_unpacker #(.MAX_CODE(MAX_CODE)) dut (
    .clk(clk), .rst_n(rst_n), .sync(sync),
    .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .code_out(code_out), .code_valid(code_valid), .code_ready(code_ready),
    .code_err(code_err), .code_cnt(code_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a plain queue of bits, oldest first.
  bit          mq[$];
  int          m_cnt_codes = 0;
  logic [6:0]  got_codes[$];
  logic        got_errs[$];
  bit          last_accept;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] model_code();
    logic [6:0] c = 7'd0;
    if (mq.size() >= 7)
      for (int i = 0; i < 7; i++) c[6-i] = mq[i];
    return c;
  endfunction

  function automatic void model_clear();
    mq.delete();
    m_cnt_codes = 0;
  endfunction

  // One clock: compare all outputs against the model at the falling edge,
  // then advance the model with the handshakes that happen at the rising edge.
  task automatic step();
    bit         e_ready, e_valid, e_err, acc, pp;
    logic [6:0] e_code;
    @(negedge clk);
    e_ready = (mq.size() <= 6) && !sync;
    e_valid = (mq.size() >= 7) && !sync;
    e_code  = model_code();
    e_err   = e_valid && (int'(e_code) > int'(MAX_CODE));
    check_eq("in_ready",   in_ready,   e_ready);
    check_eq("code_valid", code_valid, e_valid);
    check_eq("code_out",   code_out,   e_code);
    check_eq("code_err",   code_err,   e_err);
    check_eq("code_cnt",   code_cnt,   m_cnt_codes);
    acc = in_valid && e_ready;
    pp  = e_valid && code_ready;
    if (pp) begin
      got_codes.push_back(code_out);
      got_errs.push_back(code_err);
    end
    @(posedge clk);
    if (sync) model_clear();
    else begin
      if (pp) begin
        for (int i = 0; i < 7; i++) void'(mq.pop_front());
        m_cnt_codes = (m_cnt_codes + 1) % 65536;
      end
      if (acc) for (int i = 7; i >= 0; i--) mq.push_back(in_byte[i]);
    end
    last_accept = acc;
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    in_byte  = b;
    in_valid = 1'b1;
    last_accept = 1'b0;
    while (!last_accept && guard < 20) begin
      step();
      guard++;
    end
    if (!last_accept) check_eq("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic sync_pulse();
    sync = 1'b1;
    step();
    sync = 1'b0;
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; sync = 1'b0; in_byte = 8'h00; in_valid = 1'b0; code_ready = 1'b0;
    #3;
    check_eq("rst_in_ready",   in_ready,   1);
    check_eq("rst_code_valid", code_valid, 0);
    check_eq("rst_code_out",   code_out,   0);
    check_eq("rst_code_err",   code_err,   0);
    check_eq("rst_code_cnt",   code_cnt,   0);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    // Two small codes.
    code_ready = 1'b1;
    got_codes.delete(); got_errs.delete();
    send_byte(8'h02);
    send_byte(8'h04);
    idle(2);
    check_eq("seq1_ncodes", got_codes.size(), 2);
    for (int i = 0; i < got_codes.size(); i++) check_eq("seq1_code", got_codes[i], 7'h01);
    check_eq("seq1_cnt", code_cnt, 2);
    check_eq("seq1_valid", code_valid, 0);
    check_eq("seq1_left", mq.size(), 2);

    // 7 bytes of 0xFF from a clean boundary give 8 codes of 0x7F.
    sync_pulse();
    got_codes.delete(); got_errs.delete();
    for (int i = 0; i < 7; i++) send_byte(8'hFF);
    idle(3);
    check_eq("ff_ncodes", got_codes.size(), 8);
    for (int i = 0; i < got_codes.size(); i++) begin
      check_eq("ff_code", got_codes[i], 7'h7F);
      check_eq("ff_err",  got_errs[i],  1);
    end
    check_eq("ff_cnt", code_cnt, 8);
    check_eq("ff_left", mq.size(), 0);

    // Backpressure: code held stable while not consumed.
    code_ready = 1'b0;
    send_byte(8'hFE);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("bp_hold_code", code_out, 7'h7F);
      check_eq("bp_hold_rdy",  in_ready, 0);
    end
    in_valid = 1'b0;
    code_ready = 1'b1;
    step();
    check_eq("bp_left", mq.size(), 1);
    check_eq("bp_rdy",  in_ready, 1);

    // Sync drops leftovers and clears the counter.
    send_byte(8'h02);
    in_valid = 1'b1; in_byte = 8'hAA;
    sync_pulse();
    check_eq("sync_no_accept", last_accept, 0);
    in_valid = 1'b0;
    check_eq("sync_valid", code_valid, 0);
    check_eq("sync_cnt",   code_cnt, 0);
    got_codes.delete(); got_errs.delete();
    send_byte(8'hBC);
    idle(1);
    check_eq("sync_ncodes", got_codes.size(), 1);
    if (got_codes.size() == 1) begin
      check_eq("sync_code", got_codes[0], 7'h5E);
      check_eq("sync_err",  got_errs[0], 0);
    end

    // Asynchronous reset mid-stream at cnt=12.
    sync_pulse();
    code_ready = 1'b1;
    in_valid = 1'b1;
    guard = 0;
    while (mq.size() != 12 && guard < 40) begin
      in_byte = 8'($urandom);
      step();
      guard++;
    end
    in_valid = 1'b0;
    check_eq("reach_cnt12", mq.size(), 12);
    check_eq("cnt12_valid", code_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("arst_in_ready",   in_ready,   1);
    check_eq("arst_code_valid", code_valid, 0);
    check_eq("arst_code_out",   code_out,   0);
    check_eq("arst_code_cnt",   code_cnt,   0);
    model_clear();
    #1 rst_n = 1'b1;
    got_codes.delete(); got_errs.delete();
    send_byte(8'h02);
    idle(1);
    check_eq("arst_ncodes", got_codes.size(), 1);
    if (got_codes.size() == 1) check_eq("arst_code", got_codes[0], 7'h01);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_byte    = 8'($urandom);
      code_ready = ($urandom_range(0, 3) != 0);
      sync       = ($urandom_range(0, 99) == 0);
      step();
    end
    sync = 1'b0; in_valid = 1'b0;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
